// File: rtl/axi_sram_slave_if.sv
// AXI3 bus bundle between the CPU-side master and the SRAM responder.
// Carries AR/R/AW/W/B channels; master and slave modports fix directions.
interface axi_sram_slave_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI3 single-port SRAM responder: INCR bursts of 32-bit words, byte strobes.
// Ports: aclk, areset (async, active high), bus (axi_sram_slave_if.slave).
module axi_sram_slave #(
    parameter int    MEM_WORDS  = 16384,
    parameter int    READ_DELAY = 0,
    parameter string INIT_FILE  = ""
) (
    input  logic              aclk,
    input  logic              areset,
    axi_sram_slave_if.slave   bus
);
    localparam int         AW       = $clog2(MEM_WORDS);
    localparam logic [3:0] DLY_LAST = 4'(READ_DELAY > 0 ? READ_DELAY - 1 : 0);
    localparam logic [1:0] OKAY     = 2'b00;
    localparam logic [1:0] SLVERR   = 2'b10;

    logic [31:0] mem [MEM_WORDS];

    logic unused_ok;
    assign unused_ok = ^{bus.arlock, bus.arcache, bus.arprot,
                         bus.awlock, bus.awcache, bus.awprot};

    // ---------------- read channel ----------------
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_t;
    r_state_t    r_state, r_next;
    logic [31:0] r_addr;
    logic [31:0] r_addr_nx;
    logic [3:0]  r_len, r_beat, r_cnt;
    logic        r_last_beat, ar_hs, r_hs;

    assign r_addr_nx   = r_addr + 32'd4;
    assign r_last_beat = (r_beat == r_len);
    assign ar_hs       = (r_state == R_IDLE) && bus.arvalid;
    assign r_hs        = (r_state == R_BURST) && bus.rready;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    always_comb begin
        r_next      = r_state;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rlast   = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                bus.arready = 1'b1;
                if (bus.arvalid)
                    r_next = (READ_DELAY == 0) ? R_BURST : R_WAIT;
            end
            R_WAIT: begin
                if (r_cnt == DLY_LAST) r_next = R_BURST;
            end
            R_BURST: begin
                bus.rvalid = 1'b1;
                bus.rlast  = r_last_beat;
                if (bus.rready && r_last_beat) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // rdata is always the word for the beat on offer; the next word is
    // fetched on the same edge that retires the current beat.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_addr    <= '0;
            r_len     <= '0;
            r_beat    <= '0;
            r_cnt     <= '0;
            bus.rid   <= '0;
            bus.rdata <= '0;
            bus.rresp <= OKAY;
        end else if (ar_hs) begin
            r_addr    <= bus.araddr;
            r_len     <= bus.arlen;
            r_beat    <= '0;
            r_cnt     <= '0;
            bus.rid   <= bus.arid;
            bus.rresp <= (bus.arsize != 3'b010 || bus.arburst != 2'b01)
                         ? SLVERR : OKAY;
            if (READ_DELAY == 0)
                bus.rdata <= mem[bus.araddr[2 +: AW]];
        end else if (r_state == R_WAIT) begin
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == DLY_LAST)
                bus.rdata <= mem[r_addr[2 +: AW]];
        end else if (r_hs) begin
            r_addr    <= r_addr_nx;
            r_beat    <= r_beat + 4'd1;
            bus.rdata <= mem[r_addr_nx[2 +: AW]];
        end
    end

    // ---------------- write channel ----------------
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    w_state_t    w_state, w_next;
    logic [31:0] w_addr;
    logic [3:0]  w_id, w_len, w_beat;
    logic        w_err, w_err_now, w_last_beat, aw_hs, w_hs;

    assign w_last_beat = (w_beat == w_len);
    assign aw_hs       = (w_state == W_IDLE) && bus.awvalid;
    assign w_hs        = (w_state == W_DATA) && bus.wvalid;
    // A bad beat is itself suppressed; earlier good beats stay written.
    assign w_err_now   = w_err || (bus.wid != w_id) || (bus.wlast != w_last_beat);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    always_comb begin
        w_next      = w_state;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        bus.bid     = w_id;
        bus.bresp   = w_err ? SLVERR : OKAY;
        unique case (w_state)
            W_IDLE: begin
                bus.awready = 1'b1;
                if (bus.awvalid) w_next = W_DATA;
            end
            W_DATA: begin
                bus.wready = 1'b1;
                if (bus.wvalid && w_last_beat) w_next = W_RESP;
            end
            W_RESP: begin
                bus.bvalid = 1'b1;
                if (bus.bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_addr <= '0;
            w_id   <= '0;
            w_len  <= '0;
            w_beat <= '0;
            w_err  <= 1'b0;
        end else if (aw_hs) begin
            w_addr <= bus.awaddr;
            w_id   <= bus.awid;
            w_len  <= bus.awlen;
            w_beat <= '0;
            w_err  <= (bus.awsize != 3'b010 || bus.awburst != 2'b01);
        end else if (w_hs) begin
            w_addr <= w_addr + 32'd4;
            w_beat <= w_beat + 4'd1;
            w_err  <= w_err_now;
        end
    end

    always_ff @(posedge aclk) begin
        if (w_hs && !w_err_now) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.wstrb[k])
                    mem[w_addr[2 +: AW]][8*k +: 8] <= bus.wdata[8*k +: 8];
            end
        end
    end
endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: vector table plus R-beat scoreboard.
// Second instance with READ_DELAY=3 covers read latency and mid-burst reset.
module tb_axi_sram_slave;
    logic aclk = 1'b0;
    logic rst  = 1'b1;
    logic rst3 = 1'b1;

    always #5 aclk = ~aclk;

    axi_sram_slave_if b0();
    axi_sram_slave_if b3();

    axi_sram_slave #(.MEM_WORDS(16384), .READ_DELAY(0), .INIT_FILE("")) dut (
        .aclk(aclk), .areset(rst), .bus(b0));

    axi_sram_slave #(.MEM_WORDS(16384), .READ_DELAY(3), .INIT_FILE("")) dut3 (
        .aclk(aclk), .areset(rst3), .bus(b3));

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [1:0]  resp;
        logic [3:0]  id;
    } beat_t;

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] raddr;
        logic [3:0]  len;
        logic [1:0]  awburst;
        logic [1:0]  arburst;
        logic [3:0]  strb;
        logic [31:0] seed;
        logic [3:0]  id;
        logic [1:0]  bresp;
        logic [1:0]  rresp;
    } vec_t;

    beat_t       q[$];
    beat_t       e;
    logic [31:0] model [int];
    vec_t        vt [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    // R monitor: samples mid-cycle, so inputs and outputs are both stable.
    logic        stalled = 1'b0;
    logic [31:0] st_data;
    logic        st_last;

    always @(negedge aclk) begin
        if (!rst) begin
            if (stalled && b0.rvalid) begin
                chk("r_hold_data", b0.rdata, st_data);
                chk("r_hold_last", 32'(b0.rlast), 32'(st_last));
            end
            stalled = b0.rvalid && !b0.rready;
            st_data = b0.rdata;
            st_last = b0.rlast;
            if (b0.rvalid && b0.rready) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL r_extra_beat: got data %h want no beat", b0.rdata);
                end else begin
                    e = q.pop_front();
                    chk("rdata", b0.rdata, e.data);
                    chk("rlast", 32'(b0.rlast), 32'(e.last));
                    chk("rresp", 32'(b0.rresp), 32'(e.resp));
                    chk("rid", 32'(b0.rid), 32'(e.id));
                end
            end
        end
    end

    task automatic model_write(input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s);
        int k;
        logic [31:0] t;
        k = int'(a[15:2]);
        t = model.exists(k) ? model[k] : 32'hxxxx_xxxx;
        for (int b = 0; b < 4; b++)
            if (s[b]) t[8*b +: 8] = d[8*b +: 8];
        model[k] = t;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [3:0] len,
                      input logic [1:0] burst, input logic [3:0] strb,
                      input logic [31:0] seed, input logic [3:0] id,
                      input bit bad_wid, input logic [1:0] exp_bresp);
        int n;
        b0.awid    = id;
        b0.awaddr  = addr;
        b0.awlen   = len;
        b0.awsize  = 3'b010;
        b0.awburst = burst;
        b0.awvalid = 1'b1;
        n = 0;
        while (!b0.awready && n < 50) begin tick; n++; end
        chk("aw_ready", 32'(b0.awready), 32'd1);
        tick;
        b0.awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            b0.wid    = bad_wid ? (id ^ 4'h1) : id;
            b0.wdata  = seed + 32'(i);
            b0.wstrb  = strb;
            b0.wlast  = (i == int'(len));
            b0.wvalid = 1'b1;
            n = 0;
            while (!b0.wready && n < 50) begin tick; n++; end
            chk("w_ready", 32'(b0.wready), 32'd1);
            if (exp_bresp == 2'b00)
                model_write(addr + 32'(4 * i), seed + 32'(i), strb);
            tick;
        end
        b0.wvalid = 1'b0;
        b0.wlast  = 1'b0;
        b0.bready = 1'b1;
        n = 0;
        while (!b0.bvalid && n < 50) begin tick; n++; end
        chk("b_valid", 32'(b0.bvalid), 32'd1);
        chk("bresp", 32'(b0.bresp), 32'(exp_bresp));
        chk("bid", 32'(b0.bid), 32'(id));
        tick;
        b0.bready = 1'b0;
    endtask

    task automatic push_model(input logic [31:0] addr, input logic [3:0] len,
                              input logic [1:0] resp, input logic [3:0] id);
        beat_t       b;
        logic [31:0] a;
        int          k;
        for (int i = 0; i <= int'(len); i++) begin
            a = addr + 32'(4 * i);
            k = int'(a[15:2]);
            b.data = model.exists(k) ? model[k] : 32'hxxxx_xxxx;
            b.last = (i == int'(len));
            b.resp = resp;
            b.id   = id;
            q.push_back(b);
        end
    endtask

    task automatic run_read(input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] burst, input logic [3:0] id,
                            input bit toggle);
        int n;
        b0.arid    = id;
        b0.araddr  = addr;
        b0.arlen   = len;
        b0.arsize  = 3'b010;
        b0.arburst = burst;
        b0.arvalid = 1'b1;
        n = 0;
        while (!b0.arready && n < 50) begin tick; n++; end
        chk("ar_ready", 32'(b0.arready), 32'd1);
        tick;
        b0.arvalid = 1'b0;
        b0.rready  = 1'b1;
        n = 0;
        while (q.size() > 0 && n < 200) begin
            tick;
            n++;
            if (toggle) b0.rready = ~b0.rready;
        end
        chk("r_drain", 32'(q.size()), 32'd0);
        b0.rready = 1'b0;
        tick;
        chk("r_idle", 32'(b0.rvalid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int seen;
        {b0.arid, b0.araddr, b0.arlen, b0.arsize, b0.arburst} = '0;
        {b0.arlock, b0.arcache, b0.arprot, b0.arvalid, b0.rready} = '0;
        {b0.awid, b0.awaddr, b0.awlen, b0.awsize, b0.awburst} = '0;
        {b0.awlock, b0.awcache, b0.awprot, b0.awvalid} = '0;
        {b0.wid, b0.wdata, b0.wstrb, b0.wlast, b0.wvalid, b0.bready} = '0;
        {b3.arid, b3.araddr, b3.arlen, b3.arsize, b3.arburst} = '0;
        {b3.arlock, b3.arcache, b3.arprot, b3.arvalid, b3.rready} = '0;
        {b3.awid, b3.awaddr, b3.awlen, b3.awsize, b3.awburst} = '0;
        {b3.awlock, b3.awcache, b3.awprot, b3.awvalid} = '0;
        {b3.wid, b3.wdata, b3.wstrb, b3.wlast, b3.wvalid, b3.bready} = '0;

        //          waddr         raddr         len  awb    arb    strb   seed          id     bresp  rresp
        vt[0] = '{32'h0000_0100, 32'h0000_0100, 4'd7,  2'b01, 2'b01, 4'hF, 32'h0000_0000, 4'd1, 2'b00, 2'b00};
        vt[1] = '{32'h0000_0200, 32'h0000_0200, 4'd0,  2'b01, 2'b01, 4'hF, 32'hDEAD_0000, 4'd2, 2'b00, 2'b00};
        vt[2] = '{32'h0000_003C, 32'h0000_003C, 4'd15, 2'b01, 2'b01, 4'hF, 32'h1000_0000, 4'd3, 2'b00, 2'b00};
        vt[3] = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 4'd3,  2'b01, 2'b01, 4'hF, 32'h5500_0000, 4'd4, 2'b00, 2'b00};
        vt[4] = '{32'h0001_0080, 32'h0000_0080, 4'd1,  2'b01, 2'b01, 4'hF, 32'h7700_0000, 4'd5, 2'b00, 2'b00};
        vt[5] = '{32'h0000_0100, 32'h0000_0100, 4'd1,  2'b10, 2'b01, 4'hF, 32'hBAD0_0000, 4'd6, 2'b10, 2'b00};
        vt[6] = '{32'h0000_0104, 32'h0000_0104, 4'd3,  2'b01, 2'b10, 4'hF, 32'h6600_0000, 4'd7, 2'b00, 2'b10};

        repeat (3) tick;
        rst  = 1'b0;
        rst3 = 1'b0;
        tick;
        chk("rst_arready", 32'(b0.arready), 32'd1);
        chk("rst_awready", 32'(b0.awready), 32'd1);
        chk("rst_rvalid", 32'(b0.rvalid), 32'd0);
        chk("rst_bvalid", 32'(b0.bvalid), 32'd0);
        chk("rst_wready", 32'(b0.wready), 32'd0);
        chk("rst_rdata", b0.rdata, 32'd0);

        for (int v = 0; v < 7; v++) begin
            wr(vt[v].waddr, vt[v].len, vt[v].awburst, vt[v].strb,
               vt[v].seed, vt[v].id, 1'b0, vt[v].bresp);
            push_model(vt[v].raddr, vt[v].len, vt[v].rresp, vt[v].id);
            run_read(vt[v].raddr, vt[v].len, vt[v].arburst, vt[v].id, 1'b0);
        end

        // byte strobes merge into the existing word
        wr(32'h40, 4'd0, 2'b01, 4'hF, 32'hAABB_CCDD, 4'd8, 1'b0, 2'b00);
        wr(32'h40, 4'd0, 2'b01, 4'b0101, 32'h1122_3344, 4'd8, 1'b0, 2'b00);
        e.data = 32'hAA22_CC44;
        e.last = 1'b1;
        e.resp = 2'b00;
        e.id   = 4'd8;
        q.push_back(e);
        run_read(32'h40, 4'd0, 2'b01, 4'd8, 1'b0);

        // rready toggling: held beats checked by the monitor
        push_model(32'h100, 4'd7, 2'b00, 4'd9);
        run_read(32'h100, 4'd7, 2'b01, 4'd9, 1'b1);

        // wid mismatch: SLVERR, bid echoes awid, memory untouched
        wr(32'h200, 4'd0, 2'b01, 4'hF, 32'h9999_9999, 4'd10, 1'b1, 2'b10);
        push_model(32'h200, 4'd0, 2'b00, 4'd10);
        run_read(32'h200, 4'd0, 2'b01, 4'd10, 1'b0);

        // W data before AW is stalled
        b0.wvalid = 1'b1;
        b0.wdata  = 32'h0BAD_0BAD;
        tick;
        tick;
        chk("w_early_stall", 32'(b0.wready), 32'd0);
        b0.wvalid = 1'b0;

        // read and write channels concurrently
        push_model(32'h100, 4'd7, 2'b00, 4'd11);
        fork
            run_read(32'h100, 4'd7, 2'b01, 4'd11, 1'b1);
            wr(32'h600, 4'd3, 2'b01, 4'hF, 32'h6060_0000, 4'd12, 1'b0, 2'b00);
        join
        push_model(32'h600, 4'd3, 2'b00, 4'd12);
        run_read(32'h600, 4'd3, 2'b01, 4'd12, 1'b0);

        // READ_DELAY=3 instance: latency, then reset mid-burst
        b3.arid    = 4'd1;
        b3.araddr  = 32'h0;
        b3.arlen   = 4'd1;
        b3.arsize  = 3'b010;
        b3.arburst = 2'b01;
        b3.rready  = 1'b0;
        b3.arvalid = 1'b1;
        chk("d3_arready", 32'(b3.arready), 32'd1);
        tick;
        b3.arvalid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("d3_rvalid_t%0d", c), 32'(b3.rvalid), (c == 4) ? 32'd1 : 32'd0);
            if (c < 4) tick;
        end
        tick;
        chk("d3_rvalid_held", 32'(b3.rvalid), 32'd1);
        chk("d3_rlast_first", 32'(b3.rlast), 32'd0);
        rst3 = 1'b1;
        #1;
        chk("d3_rst_rvalid", 32'(b3.rvalid), 32'd0);
        chk("d3_rst_arready", 32'(b3.arready), 32'd1);
        tick;
        rst3 = 1'b0;
        b3.rready = 1'b1;
        seen = 0;
        repeat (8) begin
            tick;
            if (b3.rvalid) seen++;
        end
        chk("d3_no_r_after_rst", 32'(seen), 32'd0);
        chk("d3_bvalid", 32'(b3.bvalid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
